// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;

  localparam int RD_LAT_DEFAULT = 1;

  typedef struct packed {
    logic valid;
    logic id;
    logic err;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic pri;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (pri == ID1) ? 2'b10 : 2'b01;
    end
  end

  // After an accept the other requester gets priority on the next tie.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pri <= ID0;
    end else if (accept) begin
      pri <= gnt[0] ? ID1 : ID0;
    end
  end

endmodule

// File: rtl/ram_arb2.sv
// Shares the ram_top write and read ports between two clients, each port with
// its own round-robin arbiter; read data is routed back in accept order.
module ram_arb2
  import ram_arb_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = RD_LAT_DEFAULT
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  input  logic              i_req_0,
  input  logic              i_req_1,
  input  logic              i_we_0,
  input  logic              i_we_1,
  input  logic [ADDR_W-1:0] i_addr_0,
  input  logic [ADDR_W-1:0] i_addr_1,
  input  logic [WIDTH-1:0]  i_wdata_0,
  input  logic [WIDTH-1:0]  i_wdata_1,
  output logic              o_gnt_0,
  output logic              o_gnt_1,
  output logic              o_rvalid_0,
  output logic              o_rvalid_1,
  output logic [WIDTH-1:0]  o_rdata_0,
  output logic [WIDTH-1:0]  o_rdata_1,
  output logic              o_err_0,
  output logic              o_err_1,
  output logic              o_ram_wr,
  output logic [ADDR_W-1:0] o_ram_wr_addr,
  output logic [WIDTH-1:0]  o_ram_wr_data,
  output logic              o_ram_rd,
  output logic [ADDR_W-1:0] o_ram_rd_addr,
  input  logic [WIDTH-1:0]  i_ram_rd_data
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        wr_cand, rd_cand, wr_gnt, rd_gnt;
  logic              wr_acc, rd_acc, wr_id, rd_id, wr_bad, rd_bad;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [WIDTH-1:0]  wr_data;
  tag_t              tag_in, tag_out;
  tag_t              tag_pipe [RD_LAT+1];

  assign wr_cand = {i_req_1 & i_we_1, i_req_0 & i_we_0};
  assign rd_cand = {i_req_1 & ~i_we_1, i_req_0 & ~i_we_0};

  rr_arb2 u_wr_arb (
    .i_sys_clk (i_sys_clk),
    .i_rst_n   (i_rst_n),
    .req       (wr_cand),
    .accept    (wr_acc),
    .gnt       (wr_gnt)
  );

  rr_arb2 u_rd_arb (
    .i_sys_clk (i_sys_clk),
    .i_rst_n   (i_rst_n),
    .req       (rd_cand),
    .accept    (rd_acc),
    .gnt       (rd_gnt)
  );

  assign wr_acc  = |wr_gnt;
  assign rd_acc  = |rd_gnt;
  assign wr_id   = wr_gnt[1];
  assign rd_id   = rd_gnt[1];
  assign wr_addr = wr_id ? i_addr_1 : i_addr_0;
  assign wr_data = wr_id ? i_wdata_1 : i_wdata_0;
  assign rd_addr = rd_id ? i_addr_1 : i_addr_0;
  assign wr_bad  = {1'b0, wr_addr} >= DEPTH_EXT;
  assign rd_bad  = {1'b0, rd_addr} >= DEPTH_EXT;

  assign o_gnt_0 = wr_gnt[0] | rd_gnt[0];
  assign o_gnt_1 = wr_gnt[1] | rd_gnt[1];

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ram_wr      <= 1'b0;
      o_ram_wr_addr <= '0;
      o_ram_wr_data <= '0;
      o_ram_rd      <= 1'b0;
      o_ram_rd_addr <= '0;
      o_err_0       <= 1'b0;
      o_err_1       <= 1'b0;
    end else begin
      o_ram_wr <= wr_acc && !wr_bad;
      o_ram_rd <= rd_acc && !rd_bad;
      if (wr_acc && !wr_bad) begin
        o_ram_wr_addr <= wr_addr;
        o_ram_wr_data <= wr_data;
      end
      if (rd_acc && !rd_bad) begin
        o_ram_rd_addr <= rd_addr;
      end
      o_err_0 <= (wr_acc && wr_bad && wr_id == ID0) || (rd_acc && rd_bad && rd_id == ID0);
      o_err_1 <= (wr_acc && wr_bad && wr_id == ID1) || (rd_acc && rd_bad && rd_id == ID1);
    end
  end

  // Illegal reads still ride the pipeline so returns stay in accept order.
  assign tag_in  = '{valid: rd_acc, id: rd_id, err: rd_bad};
  assign tag_out = tag_pipe[RD_LAT];

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rvalid_0 <= 1'b0;
      o_rvalid_1 <= 1'b0;
      o_rdata_0  <= '0;
      o_rdata_1  <= '0;
    end else begin
      o_rvalid_0 <= tag_out.valid && tag_out.id == ID0;
      o_rvalid_1 <= tag_out.valid && tag_out.id == ID1;
      if (tag_out.valid && tag_out.id == ID0) begin
        o_rdata_0 <= tag_out.err ? '0 : i_ram_rd_data;
      end
      if (tag_out.valid && tag_out.id == ID1) begin
        o_rdata_1 <= tag_out.err ? '0 : i_ram_rd_data;
      end
    end
  end

endmodule
